// File: rtl/axi_rd_dma.sv
// axi_rd_dma -- AXI4 read-channel DMA engine feeding an AXI4-Stream master.
//
// A command gives a start byte address and a total beat count. The engine
// splits the command into INCR bursts of at most MAX_BURST beats, with only one
// burst outstanding at a time. It forwards each R beat straight onto the
// stream port and asserts tlast only on the final beat of the whole command.
//
// Optional feature: define AXI_RD_DMA_4K_SPLIT_EN to stop bursts from crossing
// a 4 KB address boundary. When undefined, burst length is limited only by the
// remaining beats and MAX_BURST.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   cmd_valid/ready/addr/beats  command handshake, start address, beat count
//   busy, done, err        status: in progress, one-cycle completion, sticky error
//   M_AXI_ar*              AXI read address channel (master)
//   M_AXI_r*               AXI read data channel (master)
//   m_axis_t*              AXI4-Stream output (tdata, tvalid, tlast, tready)
module axi_rd_dma #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int MAX_BURST  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
    output logic [7:0]            M_AXI_arlen,
    output logic [ID_WIDTH-1:0]   M_AXI_arid,
    output logic [2:0]            M_AXI_arsize,
    output logic [1:0]            M_AXI_arburst,
    output logic [3:0]            M_AXI_arcache,
    output logic                  M_AXI_arlock,
    output logic [2:0]            M_AXI_arprot,
    output logic [3:0]            M_AXI_arqos,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    input  logic [ID_WIDTH-1:0]   M_AXI_rid,
    input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rlast,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int SIZE_L = $clog2(BYTES);
    localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(AXI_ID);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [15:0]           remaining_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [16:0]           burst_beats;
    logic [ADDR_WIDTH-1:0] burst_bytes;
    logic                  cmd_fire, ar_fire, r_fire;

    assign cmd_fire = (state_q == S_IDLE) && cmd_valid;
    assign ar_fire  = (state_q == S_AR) && M_AXI_arready;
    assign r_fire   = (state_q == S_DATA) && M_AXI_rvalid && m_axis_tready;

    // Beats in the next burst: remaining, capped by MAX_BURST and optionally
    // by the distance to the next 4 KB boundary (address is beat aligned, so
    // the boundary limit is never zero).
`ifdef AXI_RD_DMA_4K_SPLIT_EN
    logic [12:0] bound_bytes;
    logic [16:0] bound_beats;
    assign bound_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign bound_beats = {4'b0, bound_bytes} >> SIZE_L;
`endif

    always_comb begin
        burst_beats = {1'b0, remaining_q};
        if (burst_beats > 17'(MAX_BURST))
            burst_beats = 17'(MAX_BURST);
`ifdef AXI_RD_DMA_4K_SPLIT_EN
        if (burst_beats > bound_beats)
            burst_beats = bound_beats;
`else
        burst_beats = burst_beats;
`endif
    end

    // len_q holds the arlen actually issued, since remaining_q moves during DATA.
    assign burst_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << SIZE_L;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                remaining_q <= cmd_beats;
                err_q       <= 1'b0;
            end else if (r_fire) begin
                remaining_q <= remaining_q - 16'd1;
                if ((M_AXI_rresp != 2'b00) || (M_AXI_rid != ID_C))
                    err_q <= 1'b1;
            end
        end
    end

    // Address and burst length are data; they are always rewritten before use.
    always_ff @(posedge ACLK) begin
        if (cmd_fire)
            addr_q <= cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
        else if (r_fire && M_AXI_rlast)
            addr_q <= addr_q + burst_bytes;
        if (ar_fire)
            len_q <= M_AXI_arlen;
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        M_AXI_arvalid = 1'b0;
        M_AXI_rready  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = (cmd_beats == 16'd0) ? S_DONE : S_AR;
            end
            S_AR: begin
                busy          = 1'b1;
                M_AXI_arvalid = 1'b1;
                if (M_AXI_arready)
                    state_d = S_DATA;
            end
            S_DATA: begin
                busy          = 1'b1;
                M_AXI_rready  = m_axis_tready;
                m_axis_tvalid = M_AXI_rvalid;
                // tlast marks the end of the command, not the end of each burst.
                m_axis_tlast  = (remaining_q == 16'd1);
                if (r_fire && M_AXI_rlast)
                    state_d = (remaining_q > 16'd1) ? S_AR : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err           = err_q;
    assign m_axis_tdata  = M_AXI_rdata;
    assign M_AXI_araddr  = addr_q;
    assign M_AXI_arlen   = 8'(burst_beats - 17'd1);
    assign M_AXI_arid    = ID_C;
    assign M_AXI_arsize  = 3'(SIZE_L);
    assign M_AXI_arburst = 2'b01;
    assign M_AXI_arcache = 4'b0000;
    assign M_AXI_arlock  = 1'b0;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arqos   = 4'b0000;

endmodule

// File: tb/tb_axi_rd_dma.sv
`timescale 1ns/1ps
module tb_axi_rd_dma;
    localparam int DW = 256;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int MB = 16;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cmd_valid, cmd_ready, busy, done, err;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_beats;
    logic [AW-1:0] M_AXI_araddr;
    logic [7:0]    M_AXI_arlen;
    logic [IW-1:0] M_AXI_arid, M_AXI_rid;
    logic [2:0]    M_AXI_arsize, M_AXI_arprot;
    logic [1:0]    M_AXI_arburst, M_AXI_rresp;
    logic [3:0]    M_AXI_arcache, M_AXI_arqos;
    logic          M_AXI_arlock, M_AXI_arvalid, M_AXI_arready;
    logic [DW-1:0] M_AXI_rdata, m_axis_tdata;
    logic          M_AXI_rlast, M_AXI_rvalid, M_AXI_rready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;

    always #5 ACLK = ~ACLK;

    axi_rd_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(0), .MAX_BURST(MB)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .busy(busy), .done(done), .err(err),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arid(M_AXI_arid),
        .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arcache(M_AXI_arcache),
        .M_AXI_arlock(M_AXI_arlock), .M_AXI_arprot(M_AXI_arprot), .M_AXI_arqos(M_AXI_arqos),
        .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
        .M_AXI_rid(M_AXI_rid), .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
        .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Reference model: expected AR requests and stream beats for a command.
    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    logic [31:0] exp_word[$];
    logic        exp_last[$];
    logic [31:0] cap_ar_addr[$];
    logic [7:0]  cap_ar_len[$];
    logic [31:0] cap_word[$];
    logic        cap_last[$];

    function automatic void model_cmd(input logic [31:0] a, input int beats);
        int addr;
        int rem;
        int n;
        addr = int'(a & ~32'h1f);
        rem  = beats;
        while (rem > 0) begin
            n = (rem < MB) ? rem : MB;
`ifdef AXI_RD_DMA_4K_SPLIT_EN
            if (n > (4096 - addr % 4096) / 32) n = (4096 - addr % 4096) / 32;
`endif
            exp_ar_addr.push_back(32'(addr));
            exp_ar_len.push_back(8'(n - 1));
            for (int i = 0; i < n; i++) begin
                exp_word.push_back(32'(addr / 32 + i + 1));
                exp_last.push_back(rem - i == 1);
            end
            addr += n * 32;
            rem  -= n;
        end
    endfunction

    function automatic void clear_logs();
        cap_ar_addr.delete(); cap_ar_len.delete(); cap_word.delete(); cap_last.delete();
    endfunction

    // Compare process: checks every AR and stream handshake against the model.
    logic        prev_ar_wait = 1'b0;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (prev_ar_wait && M_AXI_arvalid) begin
                chk("araddr_stable", M_AXI_araddr, prev_araddr);
                chk("arlen_stable", M_AXI_arlen, prev_arlen);
            end
            prev_ar_wait = M_AXI_arvalid && !M_AXI_arready;
            prev_araddr  = M_AXI_araddr;
            prev_arlen   = M_AXI_arlen;
            if (M_AXI_arvalid && M_AXI_arready) begin
                cap_ar_addr.push_back(M_AXI_araddr);
                cap_ar_len.push_back(M_AXI_arlen);
                if (exp_ar_addr.size() == 0)
                    fail_now($sformatf("ar_unexpected araddr %0h arlen %0d", M_AXI_araddr, M_AXI_arlen));
                else begin
                    chk("araddr", M_AXI_araddr, exp_ar_addr.pop_front());
                    chk("arlen", M_AXI_arlen, exp_ar_len.pop_front());
                    chk("arid", M_AXI_arid, 0);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                cap_word.push_back(m_axis_tdata[31:0]);
                cap_last.push_back(m_axis_tlast);
                if (exp_word.size() == 0)
                    fail_now($sformatf("beat_unexpected tdata %0h", m_axis_tdata[31:0]));
                else begin
                    chk("tdata", m_axis_tdata, {224'b0, exp_word.pop_front()});
                    chk("tlast", m_axis_tlast, exp_last.pop_front());
                end
            end
            if (M_AXI_rvalid)
                chk("rready_mirror", M_AXI_rready, m_axis_tready);
            if (done)
                done_cnt++;
        end else
            prev_ar_wait = 1'b0;
    end

    // Slave memory model: word i holds i+1; one burst at a time.
    logic        in_burst = 1'b0;
    logic [31:0] b_addr = '0;
    int          b_len = 0, b_idx = 0;
    int          err_beat = -1;
    bit          rand_tready = 1'b0;
    initial begin
        logic s_rst, s_ar, s_r;
        logic [31:0] s_a;
        logic [7:0]  s_l;
        M_AXI_arready = 1'b0; M_AXI_rvalid = 1'b0; M_AXI_rdata = '0;
        M_AXI_rlast = 1'b0; M_AXI_rresp = 2'b00; M_AXI_rid = '0; m_axis_tready = 1'b1;
        forever begin
            @(negedge ACLK);
            s_rst = !ARESETN;
            s_ar  = M_AXI_arvalid && M_AXI_arready;
            s_r   = M_AXI_rvalid && M_AXI_rready;
            s_a   = M_AXI_araddr;
            s_l   = M_AXI_arlen;
            @(posedge ACLK);
            #1;
            if (s_rst) in_burst = 1'b0;
            else begin
                if (s_r) begin
                    if (b_idx == b_len) in_burst = 1'b0;
                    else b_idx++;
                end
                if (s_ar) begin
                    in_burst = 1'b1; b_addr = s_a; b_len = int'(s_l); b_idx = 0;
                end
            end
            M_AXI_arready = 1'($urandom_range(0, 1));
            M_AXI_rvalid  = in_burst;
            M_AXI_rdata   = '0;
            M_AXI_rdata[31:0] = b_addr / 32 + 32'(b_idx) + 32'd1;
            M_AXI_rlast   = in_burst && (b_idx == b_len);
            M_AXI_rresp   = (in_burst && b_idx == err_beat) ? 2'b10 : 2'b00;
            M_AXI_rid     = '0;
            m_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] b);
        int base;
        int cyc;
        clear_logs();
        model_cmd(a, int'(b));
        base = done_cnt;
        @(posedge ACLK); #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = b;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        chk("err_clear_on_accept", err, 0);
        if (b == 16'd0) begin
            chk("zero_done_next_cycle", done, 1);
            chk("zero_no_arvalid", M_AXI_arvalid, 0);
        end else
            chk("busy_after_accept", busy, 1);
        cyc = 0;
        while (done_cnt == base && cyc < 3000) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        if (done_cnt == base) fail_now("done_timeout");
        @(posedge ACLK); #1;
        chk("done_one_cycle", done_cnt - base, 1);
        chk("done_low_after", done, 0);
        chk("idle_after_done", cmd_ready, 1);
        chk("busy_low_after", busy, 0);
        chk("ar_all_issued", exp_ar_addr.size(), 0);
        chk("beats_all_delivered", exp_word.size(), 0);
    endtask

    initial begin
        int cyc;
        int nlast;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_arvalid", M_AXI_arvalid, 0);
        chk("rst_rready", M_AXI_rready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("const_ar", {M_AXI_arsize, M_AXI_arburst, M_AXI_arcache, M_AXI_arlock, M_AXI_arprot, M_AXI_arqos},
            {3'd5, 2'b01, 4'd0, 1'b0, 3'd0, 4'd0});
        ARESETN = 1'b1;

        // Single beat.
        run_cmd(32'h0, 16'd1);
        chk("t1_ar_count", cap_ar_addr.size(), 1);
        chk("t1_araddr", cap_ar_addr[0], 32'h0);
        chk("t1_arlen", cap_ar_len[0], 0);
        chk("t1_tdata", cap_word[0], 1);
        chk("t1_tlast", cap_last[0], 1);
        chk("t1_err", err, 0);

        // Two bursts, tlast only at the end of the command.
        run_cmd(32'h0, 16'd20);
        chk("t2_ar_count", cap_ar_addr.size(), 2);
        chk("t2_araddr0", cap_ar_addr[0], 32'h0);
        chk("t2_arlen0", cap_ar_len[0], 15);
        chk("t2_araddr1", cap_ar_addr[1], 32'h200);
        chk("t2_arlen1", cap_ar_len[1], 3);
        chk("t2_beats", cap_word.size(), 20);
        chk("t2_last_word", cap_word[19], 20);
        nlast = 0;
        foreach (cap_last[i]) nlast += int'(cap_last[i]);
        chk("t2_tlast_count", nlast, 1);
        chk("t2_tlast_pos", cap_last[19], 1);

        // 4 KB boundary case.
        run_cmd(32'hFC0, 16'd4);
`ifdef AXI_RD_DMA_4K_SPLIT_EN
        chk("t3_ar_count", cap_ar_addr.size(), 2);
        chk("t3_araddr0", cap_ar_addr[0], 32'hFC0);
        chk("t3_arlen0", cap_ar_len[0], 1);
        chk("t3_araddr1", cap_ar_addr[1], 32'h1000);
        chk("t3_arlen1", cap_ar_len[1], 1);
`else
        chk("t3_ar_count", cap_ar_addr.size(), 1);
        chk("t3_araddr0", cap_ar_addr[0], 32'hFC0);
        chk("t3_arlen0", cap_ar_len[0], 3);
`endif
        chk("t3_first_word", cap_word[0], 127);

        // Randomized backpressure; unaligned address is forced down to 0x400.
        rand_tready = 1'b1;
        run_cmd(32'h40F, 16'd8);
        rand_tready = 1'b0;
        chk("t4_beats", cap_word.size(), 8);
        chk("t4_first", cap_word[0], 33);
        chk("t4_last", cap_word[7], 40);

        // Zero-beat command.
        run_cmd(32'h80, 16'd0);
        chk("t5_no_ar", cap_ar_addr.size(), 0);

        // Error response on beat 2, sticky until next command.
        err_beat = 1;
        run_cmd(32'h100, 16'd4);
        err_beat = -1;
        chk("t6_err_set", err, 1);
        repeat (3) @(posedge ACLK);
        #1;
        chk("t6_err_held", err, 1);
        run_cmd(32'h0, 16'd1);
        chk("t6_err_clear", err, 0);

        // Reset during beat 3 of an 8-beat burst.
        clear_logs();
        model_cmd(32'h200, 8);
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_beats = 16'd8;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (cap_word.size() < 2 && cyc < 500) begin
            @(posedge ACLK); #1;
            cyc++;
        end
        if (cap_word.size() < 2) fail_now("t7_beat_timeout");
        chk("t7_beat3_presented", m_axis_tvalid, 1);
        #1;
        ARESETN = 1'b0;
        #1;
        chk("t7_rst_arvalid", M_AXI_arvalid, 0);
        chk("t7_rst_rready", M_AXI_rready, 0);
        chk("t7_rst_tvalid", m_axis_tvalid, 0);
        chk("t7_rst_tlast", m_axis_tlast, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_err", err, 0);
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_word.delete(); exp_last.delete();
        @(posedge ACLK); #1;
        chk("t7_cmd_ready_after", cmd_ready, 1);
        chk("t7_busy_after", busy, 0);
        run_cmd(32'h40, 16'd2);
        chk("t7_recover_first", cap_word[0], 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
